// File: rtl/hack_rom_loader.sv
// HPS ioctl download responder: buffers 16-bit words and commits them to the
// Hack instruction ROM over a req/ack port, holding the CPU in reset meanwhile.
module hack_rom_loader #(
  parameter int FIFO_DEPTH  = 2,
  parameter int HOLD_CYCLES = 16,
  parameter bit SWAP_BYTES  = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        rom_req,
  input  logic        rom_ack,
  output logic [14:0] rom_addr,
  output logic [15:0] rom_data,
  output logic        cpu_reset,
  output logic [15:0] loaded_words,
  output logic        overflow,
  output logic        done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, HOLD} state_t;

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } rom_word_t;

  state_t          state, state_n;
  rom_word_t       mem [FIFO_DEPTH];
  rom_word_t       din;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [HW-1:0]   hold_cnt;
  logic            accept_st, in_range, full, empty;
  logic            push, drop, pop, ack_fire, start_load;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ioctl_addr[0];

  assign din.addr = ioctl_addr[15:1];
  assign din.data = SWAP_BYTES ? {ioctl_dout[7:0], ioctl_dout[15:8]} : ioctl_dout;

  // Strobes only count while a download is being taken in or drained.
  assign accept_st  = (state == LOAD) || (state == FLUSH);
  assign in_range   = (ioctl_addr[24:16] == 9'd0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign push       = accept_st && ioctl_wr && in_range && !full;
  assign drop       = accept_st && ioctl_wr && !(in_range && !full);
  assign ack_fire   = rom_req && rom_ack;
  assign pop        = !empty && (!rom_req || rom_ack);
  assign start_load = ioctl_download && ((state == IDLE) || (state == HOLD));

  assign ioctl_wait = full;
  assign cpu_reset  = (state != IDLE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ioctl_download) state_n = LOAD;
      LOAD:    if (!ioctl_download) state_n = FLUSH;
      FLUSH:   if (empty && !rom_req) state_n = HOLD;
      HOLD: begin
        if (ioctl_download)             state_n = LOAD;
        else if (hold_cnt == HW'(1))    state_n = IDLE;
      end
      default: state_n = HOLD;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= HOLD;
    else          state <= state_n;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= HW'(HOLD_CYCLES);
      done     <= 1'b0;
    end else begin
      done <= (state == HOLD) && (state_n == IDLE);
      if (state == FLUSH && state_n == HOLD)  hold_cnt <= HW'(HOLD_CYCLES);
      else if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
    end
  end

  // Storage carries no reset; validity lives entirely in count/pointers.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head is loaded the cycle the port is free or being acked, giving
  // one word per cycle when the ROM acks continuously.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_req  <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
    end else if (pop) begin
      rom_req  <= 1'b1;
      rom_addr <= mem[rd_ptr].addr;
      rom_data <= mem[rd_ptr].data;
    end else if (ack_fire) begin
      rom_req  <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      loaded_words <= '0;
      overflow     <= 1'b0;
    end else begin
      if (start_load)
        loaded_words <= '0;
      else if (ack_fire && loaded_words != 16'hFFFF)
        loaded_words <= loaded_words + 16'd1;
      if (start_load) overflow <= 1'b0;
      else if (drop)  overflow <= 1'b1;
    end
  end

endmodule
